// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: steps a one-hot LED pattern on every edge of a slow toggle.
// It either rotates the pattern as a running light or sweeps it back and forth,
// and it reports the applied step count and a wrap/bounce pulse.
module led_flow_ctrl #(
  parameter int unsigned LED_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_in,
  input  logic             mode_in,
  input  logic             pause_in,
  output logic [LED_W-1:0] led_out,
  output logic [7:0]       step_cnt,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {StInit, StRunUp, StRunDn} state_e;

  localparam logic [LED_W-1:0] LedLsb = {{(LED_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tick_q;
  logic             step;

  logic [LED_W-1:0] led_rol, led_shl, led_shr;

  assign led_rol = {led_q[LED_W-2:0], led_q[LED_W-1]};
  assign led_shl = {led_q[LED_W-2:0], 1'b0};
  assign led_shr = {1'b0, led_q[LED_W-1:1]};

  // Steps are suppressed in StInit so a high tick_in at reset release is not an edge.
  assign step = (tick_in != tick_q) && (state_q != StInit) && !pause_in;

  // Next-state: pattern movement, direction changes and wrap/bounce detection.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    case (state_q)
      StInit: state_d = StRunUp;
      StRunUp, StRunDn: begin
        if (step) begin
          cnt_d = cnt_q + 8'd1;
          if (!mode_in) begin
            // Rotate mode always runs upward, even when leaving a down sweep.
            led_d   = led_rol;
            wrap_d  = led_q[LED_W-1];
            state_d = StRunUp;
          end else if (state_q == StRunUp) begin
            if (led_q[LED_W-1]) begin
              // Already at the top (mode just changed): bounce immediately.
              led_d   = led_shr;
              state_d = StRunDn;
              wrap_d  = 1'b1;
            end else begin
              led_d = led_shl;
              if (led_q[LED_W-2]) begin
                state_d = StRunDn;
                wrap_d  = 1'b1;
              end
            end
          end else begin
            if (led_q[0]) begin
              // Bottom reached while still marked down: bounce, never shift out.
              led_d   = led_shl;
              state_d = StRunUp;
              wrap_d  = 1'b1;
            end else begin
              led_d = led_shr;
              if (led_q[1]) begin
                state_d = StRunUp;
                wrap_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  // All state and outputs registered; tick_q tracks tick_in even while paused.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StInit;
      led_q   <= LedLsb;
      cnt_q   <= 8'd0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      tick_q  <= tick_in;
    end
  end

  assign led_out    = led_q;
  assign step_cnt   = cnt_q;
  assign wrap_pulse = wrap_q;

endmodule
